// File: rtl/fir_input_sequencer_pkg.sv
// Shared types and helpers for the FIR input sequencer.
// Sample width, slot FSM encoding and clog2.
package fir_input_sequencer_pkg;

  typedef enum logic {
    EMPTY_SLOT  = 1'b0,
    SAMPLE_SLOT = 1'b1
  } slot_state_t;

  function automatic int sample_width(
    input int wi,
    input int wf
  );
    return wi + wf;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_input_sequencer_if.sv
// Sample source handshake bundle.
// Master drives data/valid, slave drives ready.
interface fir_input_sequencer_if #(
  parameter int W = 16
) ();

  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/seq_fifo.sv
// Sample FIFO for the input sequencer.
// Head is visible on dout; fill tells full from empty.
module seq_fifo
  import fir_input_sequencer_pkg::*;
#(
  parameter int WL    = 16,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WL-1:0]          din,
  output logic [WL-1:0]          dout,
  output logic [clog2(DEPTH):0]  fill
);

  localparam int AW = clog2(DEPTH);

  logic [WL-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign dout = mem[rd_ptr];

  // storage array, contents are qualified by fill
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= din;
  end

  // pointers wrap naturally; occupancy tracks push/pop
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/fir_input_sequencer.sv
// Presents one buffered sample per TAPSIZE-cycle slot to a FIR.
// Empty FIFO at a slot boundary yields a zero bubble.
module fir_input_sequencer
  import fir_input_sequencer_pkg::*;
#(
  parameter int TAPSIZE = 3,
  parameter int WI      = 1,
  parameter int WF      = 15,
  parameter int DEPTH   = 4,
  localparam int W      = sample_width(WI, WF),
  localparam int TW     = (clog2(TAPSIZE) < 1) ? 1 : clog2(TAPSIZE),
  localparam int FW     = clog2(DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  fir_input_sequencer_if.slave  src,
  output logic [W-1:0]          x,
  output logic [TW-1:0]         tap_idx,
  output logic                  sample_start,
  output logic                  underrun,
  output logic [FW-1:0]         fill
);

  localparam logic [TW-1:0] TAP_LAST = TW'(TAPSIZE - 1);
  localparam logic [FW-1:0] FULL     = FW'(DEPTH);

  slot_state_t  state;
  slot_state_t  state_nx;
  logic         run;
  logic         boundary;
  logic         push;
  logic         pop;
  logic [W-1:0] head;

  assign boundary     = (tap_idx == TAP_LAST);
  assign src.in_ready = run && (fill < FULL);
  assign push         = src.in_valid && src.in_ready;
  assign pop          = boundary && (fill != '0);

  seq_fifo #(
    .WL    (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK  (CLK),
    .RST  (RST),
    .push (push),
    .pop  (pop),
    .din  (src.in_data),
    .dout (head),
    .fill (fill)
  );

  // free-running slot phase; run marks the first edge after reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tap_idx <= TAP_LAST;
      run     <= 1'b0;
    end else begin
      run     <= 1'b1;
      tap_idx <= boundary ? '0 : tap_idx + 1'b1;
    end
  end

  // slot state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= EMPTY_SLOT;
    else      state <= state_nx;
  end

  // slot kind is decided only at boundaries
  always_comb begin
    state_nx = state;
    if (boundary) state_nx = pop ? SAMPLE_SLOT : EMPTY_SLOT;
  end

  // held sample, reloaded at each boundary
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)          x <= '0;
    else if (boundary) x <= pop ? head : '0;
  end

  // slot pulses in the first cycle of every slot
  always_comb begin
    sample_start = 1'b0;
    underrun     = 1'b0;
    if (run && tap_idx == '0) begin
      unique case (1'b1)
        (state == SAMPLE_SLOT): sample_start = 1'b1;
        default:                underrun     = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_input_sequencer.sv
// Randomized bench with a queue model of the sequencer.
// Also pins the model with hand-computed expectations.
module tb_fir_input_sequencer;

  localparam int TAPSIZE = 3;
  localparam int DEPTH   = 4;

  logic        CLK;
  logic        RST;
  logic [15:0] x;
  logic [1:0]  tap_idx;
  logic        sample_start;
  logic        underrun;
  logic [2:0]  fill;

  fir_input_sequencer_if #(.W(16)) bus ();

  fir_input_sequencer #(
    .TAPSIZE (TAPSIZE),
    .WI      (1),
    .WF      (15),
    .DEPTH   (DEPTH)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .src          (bus),
    .x            (x),
    .tap_idx      (tap_idx),
    .sample_start (sample_start),
    .underrun     (underrun),
    .fill         (fill)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  logic [15:0] mq [$];
  logic [15:0] m_x;
  int          m_tap;
  bit          m_run;
  bit          m_start;
  bit          m_und;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_x     = '0;
    m_tap   = TAPSIZE - 1;
    m_run   = 1'b0;
    m_start = 1'b0;
    m_und   = 1'b0;
  endtask

  task automatic model_step();
    bit acc;
    acc = m_run && (mq.size() < DEPTH) && bus.in_valid;
    m_start = 1'b0;
    m_und   = 1'b0;
    if (m_tap == TAPSIZE - 1) begin
      if (mq.size() > 0) begin
        m_x     = mq.pop_front();
        m_start = 1'b1;
      end else begin
        m_x   = '0;
        m_und = 1'b1;
      end
    end
    if (acc) mq.push_back(bus.in_data);
    m_tap = (m_tap + 1) % TAPSIZE;
    m_run = 1'b1;
  endtask

  always @(negedge CLK) begin
    check("in_ready", 32'(bus.in_ready),
          32'(m_run && (mq.size() < DEPTH)));
    check("tap_idx", 32'(tap_idx), 32'(m_tap));
    check("x", 32'(x), 32'(m_x));
    check("sample_start", 32'(sample_start), 32'(m_start));
    check("underrun", 32'(underrun), 32'(m_und));
    check("fill", 32'(fill), 32'(mq.size()));
  end

  task automatic cycle(input bit v, input logic [15:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge CLK);
    if (RST) model_step();
    @(negedge CLK);
  endtask

  task automatic reset_dut();
    #1;
    RST = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  logic [17:0] tap_seq;
  logic [15:0] obs [$];
  int nund, nst, nx, bad, st38, nxt, maxfill;
  bit found, started, v;

  initial begin
    RST = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    // idle source
    tap_seq = '0;
    nund = 0; nst = 0; nx = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, '0);
      tap_seq = {tap_seq[15:0], tap_idx};
      nund += int'(underrun);
      nst  += int'(sample_start);
      nx   += int'(x != '0);
    end
    check("idle_taps", 32'(tap_seq),
          32'(18'b00_01_10_00_01_10_00_01_10));
    check("idle_underruns", 32'(nund), 32'd3);
    check("idle_starts", 32'(nst), 32'd0);
    check("idle_x_nonzero", 32'(nx), 32'd0);

    // single sample accepted at tap 1
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      if (tap_idx == 2'd1) found = 1'b1;
      else cycle(1'b0, '0);
    end
    check("wait_tap1", 32'(found), 32'd1);
    cycle(1'b1, 16'h2000);
    cycle(1'b0, '0);
    check("one_x0", 32'(x), 32'h2000);
    check("one_start", 32'(sample_start), 32'd1);
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    check("one_x2", 32'(x), 32'h2000);
    check("one_tap2", 32'(tap_idx), 32'd2);
    cycle(1'b0, '0);
    check("one_bubble_x", 32'(x), 32'd0);
    check("one_bubble_und", 32'(underrun), 32'd1);

    // burst 1..6 into a 4-deep FIFO
    reset_dut();
    obs.delete();
    bad = 0; st38 = 0; nxt = 1;
    for (int i = 0; i < 30; i++) begin
      if (fill == 3'd4 && bus.in_ready) bad++;
      if (st38 == 1) begin
        check("fullpop_fill3", 32'(fill), 32'd3);
        check("fullpop_ready", 32'(bus.in_ready), 32'd1);
        st38 = 2;
      end else if (st38 == 2) begin
        check("fullpop_fill4", 32'(fill), 32'd4);
        st38 = 3;
      end
      v = (nxt <= 6);
      if (st38 == 0 && v && fill == 3'd4 && tap_idx == 2'd2)
        st38 = 1;
      if (v && bus.in_ready) begin
        cycle(1'b1, 16'(nxt));
        nxt++;
      end else begin
        cycle(v, 16'(nxt));
      end
      if (sample_start) obs.push_back(x);
    end
    check("full_no_ready", 32'(bad), 32'd0);
    check("fullpop_seen", 32'(st38), 32'd3);
    check("burst_count", 32'(obs.size()), 32'd6);
    for (int k = 0; k < obs.size(); k++)
      check("burst_order", 32'(obs[k]), 32'(k + 1));

    // reset mid-slot with fill 3
    reset_dut();
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (fill == 3'd3 && tap_idx == 2'd1) found = 1'b1;
      else cycle(1'b1, 16'($urandom));
    end
    check("wait_fill3", 32'(found), 32'd1);
    bus.in_valid = 1'b1;
    #2;
    RST = 1'b0;
    #1;
    check("rst_x", 32'(x), 32'd0);
    check("rst_tap", 32'(tap_idx), 32'd2);
    check("rst_start", 32'(sample_start), 32'd0);
    check("rst_und", 32'(underrun), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    model_reset();
    bus.in_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    cycle(1'b0, '0);
    check("rst_first_und", 32'(underrun), 32'd1);
    check("rst_first_x", 32'(x), 32'd0);
    for (int i = 0; i < 20; i++)
      cycle(1'($urandom_range(0, 1)), 16'($urandom));

    // steady source, one sample per slot
    reset_dut();
    started = 1'b0;
    nund = 0; nst = 0; maxfill = 0;
    for (int i = 0; i < 312; i++) begin
      cycle(i % 3 == 0, 16'($urandom));
      if (sample_start) begin
        started = 1'b1;
        nst++;
      end
      if (started && underrun) nund++;
      if (int'(fill) > maxfill) maxfill = int'(fill);
    end
    check("steady_underruns", 32'(nund), 32'd0);
    check("steady_fill_le2", 32'(maxfill <= 2), 32'd1);
    check("steady_slots", 32'(nst >= 100), 32'd1);

    // random traffic with an asynchronous reset in the middle
    reset_dut();
    for (int i = 0; i < 500; i++) begin
      if (i == 250) begin
        #2;
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
      end
      cycle($urandom_range(0, 99) < 45, 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
